// File: rtl/ysyx_23060332_core_seq_pkg.sv
// ysyx_23060332_core_seq_pkg: sequencer state encodings and the instruction codes it decodes
package ysyx_23060332_core_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_REQ,
    S_IF_WAIT,
    S_EX,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_e;
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
endpackage

// File: rtl/ysyx_23060332_bus_wdt.sv
// ysyx_23060332_bus_wdt: counts consecutive bus-wait cycles and flags when the limit is hit
module ysyx_23060332_bus_wdt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // restart on every state change; idle outside the wait states
  always_comb cnt_d = (clr_i || !wait_i) ? '0 : cnt_q + W'(1);
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  // fires in the last permitted wait cycle so the FSM leaves after exactly TIMEOUT_CYC cycles
  assign expired_o = wait_i && (cnt_q == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/ysyx_23060332_core_seq.sv
// ysyx_23060332_core_seq: multi-cycle fetch/execute/mem/write-back sequencer; bus timeout under YSYX_23060332_BUS_TIMEOUT_EN
module ysyx_23060332_core_seq
  import ysyx_23060332_core_seq_pkg::*;
#(
  parameter int CNT_W       = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  output logic             ifu_rsp_ready,
  output logic             inst_latch_en,
  input  logic [31:0]      inst_i,
  input  logic             exu_reg_wen_i,
  input  logic             exu_jump_en_i,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  output logic             lsu_wen,
  input  logic             lsu_rsp_valid,
  output logic             lsu_rsp_ready,
  output logic             reg_wen_o,
  output logic             pc_wen,
  output logic             pc_sel_jump,
  output logic [CNT_W-1:0] instret,
  output logic             halt_o,
  output logic             err_o
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic is_load, is_store, is_ebreak, in_wait, timeout;
  assign is_load   = inst_i[6:0] == INST_TYPE_L;
  assign is_store  = inst_i[6:0] == INST_TYPE_S;
  assign is_ebreak = inst_i == INST_EBREAK;
  assign in_wait   = state_q inside {S_IF_REQ, S_IF_WAIT, S_MEM_REQ, S_MEM_WAIT};
`ifdef YSYX_23060332_BUS_TIMEOUT_EN
  logic err_q, err_d;
  ysyx_23060332_bus_wdt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .wait_i   (in_wait),
    .clr_i    (state_d != state_q),
    .expired_o(timeout)
  );
  // error flag is sticky once a timeout drives the core into HALT
  always_comb err_d = err_q | timeout;
  // error register
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
  assign err_o = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif
  // next-state and per-state handshake/strobe outputs
  always_comb begin
    state_d       = state_q;
    instret_d     = instret_q;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    inst_latch_en = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_wen       = 1'b0;
    lsu_rsp_ready = 1'b0;
    reg_wen_o     = 1'b0;
    pc_wen        = 1'b0;
    pc_sel_jump   = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_IF_REQ;
      S_IF_REQ: begin
        ifu_req_valid = 1'b1;
        state_d       = ifu_req_ready ? S_IF_WAIT : S_IF_REQ;
      end
      S_IF_WAIT: begin
        ifu_rsp_ready = 1'b1;
        inst_latch_en = ifu_rsp_valid;
        state_d       = ifu_rsp_valid ? S_EX : S_IF_WAIT;
      end
      S_EX:       state_d = is_ebreak ? S_HALT : (is_load || is_store) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_wen       = is_store;
        state_d       = lsu_req_ready ? S_MEM_WAIT : S_MEM_REQ;
      end
      S_MEM_WAIT: begin
        lsu_rsp_ready = 1'b1;
        state_d       = lsu_rsp_valid ? S_WB : S_MEM_WAIT;
      end
      S_WB: begin
        pc_wen      = 1'b1;
        pc_sel_jump = exu_jump_en_i;
        reg_wen_o   = is_load || (!is_store && exu_reg_wen_i);
        instret_d   = instret_q + CNT_W'(1);
        state_d     = S_IF_REQ;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_HALT;
  end
  // state and retired-instruction registers
  always_ff @(posedge clk) begin
    state_q   <= rst ? S_IDLE : state_d;
    instret_q <= rst ? '0 : instret_d;
  end
  assign instret = instret_q;
  assign halt_o  = state_q == S_HALT;
endmodule

// File: tb/tb_ysyx_23060332_core_seq.sv
// tb_ysyx_23060332_core_seq: trace-model bench; each instruction expands into its expected per-cycle output sequence
module tb_ysyx_23060332_core_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0, ifu_rsp_ready, inst_latch_en;
  logic [31:0] inst_i = 32'h0;
  logic exu_reg_wen_i = 1'b0, exu_jump_en_i = 1'b0;
  logic lsu_req_valid, lsu_req_ready = 1'b0, lsu_wen, lsu_rsp_valid = 1'b0, lsu_rsp_ready;
  logic reg_wen_o, pc_wen, pc_sel_jump, halt_o, err_o;
  logic [63:0] instret;
  ysyx_23060332_core_seq #(.CNT_W(64), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .inst_latch_en(inst_latch_en), .inst_i(inst_i),
    .exu_reg_wen_i(exu_reg_wen_i), .exu_jump_en_i(exu_jump_en_i),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .reg_wen_o(reg_wen_o), .pc_wen(pc_wen), .pc_sel_jump(pc_sel_jump),
    .instret(instret), .halt_o(halt_o), .err_o(err_o)
  );
  localparam logic [10:0] E_IFQ = 11'h400, E_RSP = 11'h200, E_LAT = 11'h100, E_LRQ = 11'h080;
  localparam logic [10:0] E_WEN = 11'h040, E_LRS = 11'h020, E_RW = 11'h010, E_PC = 11'h008;
  localparam logic [10:0] E_SEL = 11'h004, E_HLT = 11'h002, E_ERR = 11'h001;
  typedef struct {
    logic [10:0] o;
    logic [63:0] ir;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miss = 0, cycle = 0;
  logic [63:0] mir = 64'd0;
  logic [10:0] act;
  assign act = {ifu_req_valid, ifu_rsp_ready, inst_latch_en, lsu_req_valid, lsu_wen, lsu_rsp_ready,
                reg_wen_o, pc_wen, pc_sel_jump, halt_o, err_o};
  always @(posedge clk) cycle <= cycle + 1;
  // single compare point: every cycle the model has an expectation for
  always @(negedge clk) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      vectors++;
      if (act !== x.o || instret !== x.ir) begin
        miss++;
        $display("FAIL trace cycle %0d: outputs %b instret %0d, required %b instret %0d",
                 cycle, act, instret, x.o, x.ir);
      end
    end
  end
  task automatic cyc(input logic [3:0] hs, input logic r, input logic [10:0] e);
    {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = hs;
    rst = r;
    q.push_back('{o: e, ir: mir});
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0d, required %0d", name, a, e);
    end
  endtask
  // a/b: IFU req/rsp wait cycles, c/d: LSU req/rsp wait cycles, abort: reset in 2nd MEM_WAIT cycle
  task automatic run_inst(input logic [31:0] inst, input logic wen, input logic jmp,
                          input int a, input int b, input int c, input int d, input bit abort);
    logic is_l, is_s;
    is_l = inst[6:0] == 7'b0000011;
    is_s = inst[6:0] == 7'b0100011;
    inst_i = inst;
    exu_reg_wen_i = wen;
    exu_jump_en_i = jmp;
    for (int i = 0; i <= a; i++) cyc({i == a, 3'b000}, 1'b0, E_IFQ);
    for (int i = 0; i <= b; i++) cyc({1'b0, i == b, 2'b00}, 1'b0, (i == b) ? (E_RSP | E_LAT) : E_RSP);
    cyc(4'b0, 1'b0, 11'h0);
    if (inst == 32'h00100073) begin
      for (int i = 0; i < 20; i++) cyc(4'b0, 1'b0, E_HLT);
      return;
    end
    if (is_l || is_s) begin
      for (int i = 0; i <= c; i++) cyc({2'b00, i == c, 1'b0}, 1'b0, is_s ? (E_LRQ | E_WEN) : E_LRQ);
      for (int i = 0; i <= d; i++) begin
        if (abort && i == 1) begin
          cyc(4'b0, 1'b1, E_LRS);
          mir = 64'd0;
          cyc(4'b0, 1'b0, 11'h0);
          return;
        end
        cyc({3'b000, i == d}, 1'b0, E_LRS);
      end
    end
    cyc(4'b0, 1'b0, E_PC | (jmp ? E_SEL : 11'h0) | ((is_l || (!is_s && wen)) ? E_RW : 11'h0));
    mir = mir + 64'd1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(4'b0, 1'b1, 11'h0);
    cyc(4'b0, 1'b0, 11'h0);
    run_inst(32'h00100093, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("instret_after_addi", instret, 64'd1);
    run_inst(32'h0000006f, 1'b1, 1'b1, 1, 2, 0, 0, 1'b0);
    chk("instret_after_jal", instret, 64'd2);
    run_inst(32'h00002103, 1'b1, 1'b0, 0, 0, 0, 3, 1'b0);
    chk("instret_after_load", instret, 64'd3);
    run_inst(32'h00112023, 1'b1, 1'b0, 0, 0, 1, 0, 1'b0);
    chk("instret_after_store", instret, 64'd4);
    run_inst(32'h00002103, 1'b1, 1'b0, 0, 0, 0, 5, 1'b1);
    chk("instret_after_abort", instret, 64'd0);
    run_inst(32'h00100093, 1'b0, 1'b0, 2, 1, 0, 0, 1'b0);
    chk("instret_after_restart", instret, 64'd1);
    run_inst(32'h00100073, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("halt_held", {63'd0, halt_o}, 64'd1);
    chk("instret_after_ebreak", instret, 64'd1);
`ifdef YSYX_23060332_BUS_TIMEOUT_EN
    cyc(4'b0, 1'b1, E_HLT);
    mir = 64'd0;
    cyc(4'b0, 1'b0, 11'h0);
    for (int i = 0; i < 8; i++) cyc(4'b0, 1'b0, E_IFQ);
    for (int i = 0; i < 4; i++) cyc(4'b0, 1'b0, E_HLT | E_ERR);
    chk("err_after_timeout", {63'd0, err_o}, 64'd1);
`endif
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      miss++;
      $display("FAIL trace_drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
